// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU, one quotient bit per cycle).
// LO takes the quotient and HI the remainder; stall feeds the hazard unit.
module div_iter #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [7:0]  DivOp  = 8'b0001_1010,
  parameter logic [7:0]  DivuOp = 8'b0001_1011
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [7:0]       alucontrol,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCalc   = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             is_signed, is_div, start;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_step, rem_step;

  assign is_signed = (alucontrol == DivOp);
  assign is_div    = is_signed | (alucontrol == DivuOp);
  assign start     = en & ~annul & is_div;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  // Extra top bit keeps the carry of the shifted partial remainder for the trial subtract.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, div_q};
  assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (b == '0) begin
            state_d     = StFinish;
            quotient_d  = '1;
            remainder_d = a;
          end else begin
            state_d   = StCalc;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_abs;
            div_d     = b_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      StCalc: begin
        if (annul) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d     = StFinish;
            cnt_d       = '0;
            quotient_d  = neg_quo_q ? -quo_step : quo_step;
            remainder_d = neg_rem_q ? -rem_step : rem_step;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign stall     = ((state_q == StIdle) & start) | (state_q == StCalc);
  assign ready     = (state_q == StFinish) & ~annul;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
